// File: rtl/stub_input_buffer.sv
// ---------------------------------------------------------------------------
// stub_input_buffer
//
// Collects stub words arriving from one input link into a ping-pong buffer.
// One page is filled while the other (the "closed" page) is exposed for
// reading. Each BC0 marks the start of a new event: the page being filled is
// closed and handed to the reader, and the other page starts filling.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous, active-low reset
//   BC0         bunch-crossing boundary, high at the first word of an event
//   in_data     stub word, NULL_WORD means "no stub this cycle"
//   rd_addr     read address into the closed page
//   rd_data     registered read data (one cycle after rd_addr)
//   rd_count    number of valid stubs in the closed page
//   rd_page     index of the closed (readable) page
//   page_ready  one-cycle pulse when a page closes
//   overflow    closed page lost at least one stub
//   drop_count  total stubs dropped since reset, saturating
// ---------------------------------------------------------------------------
module stub_input_buffer #(
    parameter int                WIDTH      = 36,
    parameter int                DEPTH_LOG2 = 6,
    parameter logic [WIDTH-1:0]  NULL_WORD  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  BC0,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   rd_count,
    output logic                  rd_page,
    output logic                  page_ready,
    output logic                  overflow,
    output logic [15:0]           drop_count
);

    localparam int ENTRIES = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] WPTR_ONE = 1;
    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Two pages back to back: the page index is the address MSB.
    logic [WIDTH-1:0] mem [0:2*ENTRIES-1];

    state_t                state_q,      state_d;
    logic [DEPTH_LOG2:0]   wptr_q,       wptr_d;
    logic                  rd_page_q,    rd_page_d;
    logic [DEPTH_LOG2:0]   rd_count_q,   rd_count_d;
    logic                  overflow_q,   overflow_d;
    logic                  page_ready_q, page_ready_d;
    logic                  drop_flag_q,  drop_flag_d;
    logic [15:0]           drop_count_q, drop_count_d;
    logic [WIDTH-1:0]      rd_data_q,    rd_data_d;

    logic                  in_valid;
    logic                  page_full;
    logic                  wr_en;
    logic                  wr_page;
    logic [DEPTH_LOG2-1:0] wr_addr;

    assign in_valid  = (in_data != NULL_WORD);
    // wptr never exceeds ENTRIES, so its MSB alone means "page full".
    assign page_full = wptr_q[DEPTH_LOG2];
    // The write page is always the one not being read. Using the next
    // rd_page lets a word coincident with BC0 land in the freshly opened page.
    assign wr_page   = ~rd_page_d;

    // Next-state logic. The first BC0 after reset only starts collection:
    // there is no partial page worth handing to the reader, so no page_ready
    // pulse and no page swap.
    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        rd_page_d    = rd_page_q;
        rd_count_d   = rd_count_q;
        overflow_d   = overflow_q;
        page_ready_d = 1'b0;
        drop_flag_d  = drop_flag_q;
        drop_count_d = drop_count_q;
        wr_en        = 1'b0;
        wr_addr      = '0;

        unique case (state_q)
            IDLE: begin
                if (BC0) begin
                    state_d     = RUN;
                    drop_flag_d = 1'b0;
                    if (in_valid) begin
                        wr_en  = 1'b1;
                        wptr_d = WPTR_ONE;
                    end else begin
                        wptr_d = '0;
                    end
                end
            end
            RUN: begin
                if (BC0) begin
                    rd_count_d   = wptr_q;
                    overflow_d   = drop_flag_q;
                    rd_page_d    = ~rd_page_q;
                    page_ready_d = 1'b1;
                    drop_flag_d  = 1'b0;
                    if (in_valid) begin
                        wr_en  = 1'b1;
                        wptr_d = WPTR_ONE;
                    end else begin
                        wptr_d = '0;
                    end
                end else if (in_valid) begin
                    if (!page_full) begin
                        wr_en   = 1'b1;
                        wr_addr = wptr_q[DEPTH_LOG2-1:0];
                        wptr_d  = wptr_q + WPTR_ONE;
                    end else begin
                        drop_flag_d = 1'b1;
                        if (drop_count_q != DROP_MAX) begin
                            drop_count_d = drop_count_q + 16'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read port always follows the currently registered rd_page, so a page
    // swap takes effect on the read data one cycle after the close.
    always_comb begin
        rd_data_d = mem[{rd_page_q, rd_addr}];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            rd_page_q    <= 1'b0;
            rd_count_q   <= '0;
            overflow_q   <= 1'b0;
            page_ready_q <= 1'b0;
            drop_flag_q  <= 1'b0;
            drop_count_q <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            rd_page_q    <= rd_page_d;
            rd_count_q   <= rd_count_d;
            overflow_q   <= overflow_d;
            page_ready_q <= page_ready_d;
            drop_flag_q  <= drop_flag_d;
            drop_count_q <= drop_count_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Storage is deliberately not reset; reads beyond rd_count see stale data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_page, wr_addr}] <= in_data;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_count   = rd_count_q;
    assign rd_page    = rd_page_q;
    assign page_ready = page_ready_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
